// File: rtl/mult_pkg.sv
// Shared definitions for the 4-bit shift-and-add multiplier.
//   WIDTH   : operand width (only 4 is supported by the adder slice)
//   CNT_W   : width of the iteration counter (counts 0..WIDTH-1)
//   state_e : controller states
package mult_pkg;

  localparam int unsigned WIDTH = 4;
  localparam int unsigned CNT_W = 2;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    COMPUTE = 2'd1,
    DONE    = 2'd2
  } state_e;

endpackage

// File: rtl/ripple_carry_adder_4bit.sv
// 4-bit ripple-carry adder built from explicit full-adder cells.
//   a, b : addends
//   cin  : carry in
//   sum  : 4-bit sum
//   cout : carry out of bit 3
module ripple_carry_adder_4bit (
  input  logic [3:0] a,
  input  logic [3:0] b,
  input  logic       cin,
  output logic [3:0] sum,
  output logic       cout
);

  // Separate carry nets keep the chain free of self-referencing vectors.
  logic c1, c2, c3;

  assign sum[0] = a[0] ^ b[0] ^ cin;
  assign c1     = (a[0] & b[0]) | (cin & (a[0] ^ b[0]));

  assign sum[1] = a[1] ^ b[1] ^ c1;
  assign c2     = (a[1] & b[1]) | (c1 & (a[1] ^ b[1]));

  assign sum[2] = a[2] ^ b[2] ^ c2;
  assign c3     = (a[2] & b[2]) | (c2 & (a[2] ^ b[2]));

  assign sum[3] = a[3] ^ b[3] ^ c3;
  assign cout   = (a[3] & b[3]) | (c3 & (a[3] ^ b[3]));

endmodule

// File: rtl/shift_add_multiplier_4bit.sv
// Sequential 4x4 unsigned shift-and-add multiplier with valid/ready handshakes.
//   clk          : clock, rising edge
//   rst_n        : synchronous active-low reset
//   in_valid     : operands present
//   in_ready     : block can accept operands (state IDLE)
//   multiplicand : operand M
//   multiplier   : operand Q
//   out_valid    : product available (state DONE)
//   out_ready    : consumer takes product
//   product      : {A,Q}, meaningful only while out_valid is high
// One add/shift iteration per COMPUTE cycle, four iterations per job.
module shift_add_multiplier_4bit #(
  parameter int unsigned WIDTH = mult_pkg::WIDTH
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 in_valid,
  output logic                 in_ready,
  input  logic [WIDTH-1:0]     multiplicand,
  input  logic [WIDTH-1:0]     multiplier,
  output logic                 out_valid,
  input  logic                 out_ready,
  output logic [2*WIDTH-1:0]   product
);

  import mult_pkg::*;

  state_e             state_q, state_d;
  logic [WIDTH-1:0]   m_q, m_d;
  logic [WIDTH-1:0]   a_q, a_d;
  logic [WIDTH-1:0]   q_q, q_d;
  logic [CNT_W-1:0]   cnt_q, cnt_d;

  logic [WIDTH-1:0]   add_b;
  logic [WIDTH-1:0]   add_sum;
  logic               add_cout;

  // Gating M with Q[0] folds the "add or pass A" choice into the adder.
  assign add_b = m_q & {WIDTH{q_q[0]}};

  ripple_carry_adder_4bit u_adder (
    .a    (a_q),
    .b    (add_b),
    .cin  (1'b0),
    .sum  (add_sum),
    .cout (add_cout)
  );

  // C exists only between the add and the shift of one cycle: the shift
  // moves it into A[3] and a zero fills its place, so it is never stored.
  always_comb begin
    state_d = state_q;
    m_d     = m_q;
    a_d     = a_q;
    q_d     = q_q;
    cnt_d   = cnt_q;
    unique case (state_q)
      IDLE: begin
        if (in_valid) begin
          m_d     = multiplicand;
          q_d     = multiplier;
          a_d     = '0;
          cnt_d   = '0;
          state_d = COMPUTE;
        end
      end
      COMPUTE: begin
        a_d   = {add_cout, add_sum[WIDTH-1:1]};
        q_d   = {add_sum[0], q_q[WIDTH-1:1]};
        cnt_d = cnt_q + CNT_W'(1);
        if (cnt_q == CNT_W'(WIDTH - 1)) begin
          state_d = DONE;
        end
      end
      DONE: begin
        if (out_ready) begin
          state_d = IDLE;
        end
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q <= IDLE;
      m_q     <= '0;
      a_q     <= '0;
      q_q     <= '0;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      m_q     <= m_d;
      a_q     <= a_d;
      q_q     <= q_d;
      cnt_q   <= cnt_d;
    end
  end

  // Handshake flags decode the state register only, so a consume edge
  // can never coincide with an accept edge.
  assign in_ready  = (state_q == IDLE);
  assign out_valid = (state_q == DONE);
  assign product   = {a_q, q_q};

endmodule

// File: tb/tb_shift_add_multiplier_4bit.sv
module tb_shift_add_multiplier_4bit;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       in_valid = 1'b0;
  logic       out_ready = 1'b0;
  logic [3:0] mc = 4'd0;
  logic [3:0] mp = 4'd0;
  logic       in_ready;
  logic       out_valid;
  logic [7:0] product;

  int         n_cmp = 0;
  int         n_err = 0;
  logic [7:0] exp_q[$];
  int         ready_mode = 0;  // 0: always ready, 1: random stalls, 2: driven by test

  shift_add_multiplier_4bit #(
    .WIDTH (4)
  ) dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .in_valid     (in_valid),
    .in_ready     (in_ready),
    .multiplicand (mc),
    .multiplier   (mp),
    .out_valid    (out_valid),
    .out_ready    (out_ready),
    .product      (product)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input logic [7:0] act, input logic [7:0] req);
    n_cmp++;
    if (act !== req) begin
      n_err++;
      $display("FAIL %s: got %0d required %0d", name, act, req);
    end
  endtask

  // Consumer side: out_ready changes 2 ns after the rising edge.
  initial begin
    forever begin
      @(posedge clk);
      #2;
      if (ready_mode == 0) out_ready = 1'b1;
      else if (ready_mode == 1) out_ready = 1'($urandom_range(0, 1));
    end
  end

  // Monitor: every handshake that will complete on the next edge is scored.
  initial begin
    forever begin
      @(negedge clk);
      if (out_valid && out_ready) begin
        if (exp_q.size() == 0) begin
          n_cmp++;
          n_err++;
          $display("FAIL unexpected_result: got product %0d required no out_valid", product);
        end else begin
          check("product", product, exp_q.pop_front());
        end
      end
    end
  end

  // Waits for in_ready, presents operands for exactly one accept edge.
  task automatic issue(input logic [3:0] m, input logic [3:0] q, input logic [7:0] e,
                       input bit push);
    int n = 0;
    @(negedge clk);
    while (!in_ready && n < 100) begin
      @(negedge clk);
      n++;
    end
    if (!in_ready) begin
      n_cmp++;
      n_err++;
      $display("FAIL issue_timeout: in_ready got 0 required 1");
      return;
    end
    mc = m;
    mp = q;
    in_valid = 1'b1;
    if (push) exp_q.push_back(e);
    @(posedge clk);
    #1 in_valid = 1'b0;
  endtask

  task automatic wait_drained();
    int n = 0;
    @(negedge clk);
    while (!(in_ready && exp_q.size() == 0) && n < 200) begin
      @(negedge clk);
      n++;
    end
    if (!(in_ready && exp_q.size() == 0)) begin
      n_cmp++;
      n_err++;
      $display("FAIL drain_timeout: pending %0d required 0", exp_q.size());
    end
  endtask

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation still running at time %0t", $time);
    $fatal(1, "watchdog");
  end

  initial begin
    int n;
    // Reset: idle outputs visible after the first reset edge.
    ready_mode = 0;
    @(posedge clk);
    @(negedge clk);
    check("reset_in_ready", {7'd0, in_ready}, 8'd1);
    check("reset_out_valid", {7'd0, out_valid}, 8'd0);
    check("reset_product", product, 8'd0);
    @(posedge clk);
    #1 rst_n = 1'b1;

    // Basic 3*5: busy through edge T+5, result seen at edge T+5.
    issue(4'd3, 4'd5, 8'd15, 1'b1);
    for (int k = 0; k < 5; k++) begin
      @(negedge clk);
      check("basic_in_ready_busy", {7'd0, in_ready}, 8'd0);
      check("basic_out_valid", {7'd0, out_valid}, (k == 4) ? 8'd1 : 8'd0);
    end
    @(negedge clk);
    check("basic_back_idle", {7'd0, in_ready}, 8'd1);
    check("basic_valid_drop", {7'd0, out_valid}, 8'd0);

    // Carry and zero operands.
    issue(4'd15, 4'd15, 8'd225, 1'b1);
    issue(4'd0, 4'd9, 8'd0, 1'b1);
    issue(4'd9, 4'd0, 8'd0, 1'b1);
    wait_drained();

    // Backpressure: 12*11 held for three stalled cycles.
    ready_mode = 2;
    out_ready = 1'b0;
    issue(4'd12, 4'd11, 8'd132, 1'b1);
    n = 0;
    @(negedge clk);
    while (!out_valid && n < 20) begin
      @(negedge clk);
      n++;
    end
    for (int k = 0; k < 3; k++) begin
      check("stall_out_valid", {7'd0, out_valid}, 8'd1);
      check("stall_product", product, 8'd132);
      check("stall_in_ready", {7'd0, in_ready}, 8'd0);
      if (k < 2) @(negedge clk);
    end
    @(posedge clk);
    #2 out_ready = 1'b1;
    @(posedge clk);
    @(negedge clk);
    check("release_in_ready", {7'd0, in_ready}, 8'd1);
    check("release_out_valid", {7'd0, out_valid}, 8'd0);
    ready_mode = 0;

    // Busy-ignore: 7*6 in flight while 1*1 is offered continuously.
    issue(4'd7, 4'd6, 8'd42, 1'b1);
    mc = 4'd1;
    mp = 4'd1;
    in_valid = 1'b1;
    n = 0;
    @(negedge clk);
    while (!in_ready && n < 30) begin
      @(negedge clk);
      n++;
    end
    check("busy_first_result_done", 8'(exp_q.size()), 8'd0);
    exp_q.push_back(8'd1);
    @(posedge clk);
    #1 in_valid = 1'b0;
    wait_drained();

    // Reset after the second iteration of 10*11: job discarded.
    issue(4'd10, 4'd11, 8'd0, 1'b0);
    @(posedge clk);
    @(posedge clk);
    #1 rst_n = 1'b0;
    @(posedge clk);
    #1 rst_n = 1'b1;
    @(negedge clk);
    check("midreset_in_ready", {7'd0, in_ready}, 8'd1);
    check("midreset_out_valid", {7'd0, out_valid}, 8'd0);
    check("midreset_product", product, 8'd0);
    for (int k = 0; k < 6; k++) begin
      @(negedge clk);
      check("midreset_no_valid", {7'd0, out_valid}, 8'd0);
    end
    issue(4'd2, 4'd3, 8'd6, 1'b1);
    wait_drained();

    // All 256 pairs with random consumer stalls.
    ready_mode = 1;
    for (int i = 0; i < 16; i++) begin
      for (int j = 0; j < 16; j++) begin
        issue(4'(i), 4'(j), 8'(i * j), 1'b1);
      end
    end
    wait_drained();
    check("final_queue_empty", 8'(exp_q.size()), 8'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
